// File: rtl/run_sort_phase_if.sv
// Element type, bank address width and the load/write bus shared by run_sort_phase and its host.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 10
`endif

package run_sort_phase_pkg;
  typedef struct packed {
    logic [15:0] key;
    logic [15:0] tag;
  } tuple_pair_t;
endpackage

interface run_sort_phase_if;
  import run_sort_phase_pkg::*;

  logic                        in_valid;
  logic                        in_ready;
  tuple_pair_t                 in_data;
  logic                        in_last;
  tuple_pair_t                 even_data_out;
  tuple_pair_t                 odd_data_out;
  logic [`BANK_ADDR_WIDTH-1:0] write_addr_out;
  logic                        write_en_out;
  logic [31:0]                 stream_len_out;
  logic                        phase_done_out;

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, even_data_out, odd_data_out, write_addr_out,
    output write_en_out, stream_len_out, phase_done_out
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, even_data_out, odd_data_out, write_addr_out,
    input  write_en_out, stream_len_out, phase_done_out
  );
endinterface

// File: rtl/run_sort_phase.sv
// Loads RUN_LEN-element runs, sorts them with an odd-even transposition network and drains each
// run two elements per beat. Define RUN_SORT_EARLY_EXIT_EN to leave SORT after two clean passes.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 10
`endif

module run_sort_phase
  import run_sort_phase_pkg::*;
#(
  parameter int RUN_LEN = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            en_in,
  run_sort_phase_if.slave bus
);
  localparam int W    = $bits(tuple_pair_t);
  localparam int HALF = RUN_LEN / 2;
  localparam int SW   = $clog2(RUN_LEN);
  localparam int AW   = `BANK_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, LOAD, SORT, DRAIN, DONE} state_t;

  state_t                    r_state, w_next;
  logic [RUN_LEN-1:0][W-1:0] r_slot;
  logic [RUN_LEN-1:0][W-1:0] w_even_res, w_odd_res, w_pass_res;
  logic [HALF-1:0]           w_even_swap;
  logic [HALF-2:0]           w_odd_swap;
  logic [SW-1:0]             r_cnt, r_step;
  logic [31:0]               r_len;
  logic [AW-1:0]             r_addr, r_run_base;
  tuple_pair_t               r_even, r_odd;
  logic                      r_wen, r_done, r_last_seen;
  logic                      w_accept, w_load_end, w_sort_end, w_drain_end;

  // Compare-exchange network: even pass pairs (2i,2i+1), odd pass pairs (2i+1,2i+2).
  genvar gi;
  generate
    for (gi = 0; gi < HALF; gi++) begin : g_even
      assign w_even_swap[gi]      = r_slot[2*gi] > r_slot[2*gi+1];
      assign w_even_res[2*gi]     = w_even_swap[gi] ? r_slot[2*gi+1] : r_slot[2*gi];
      assign w_even_res[2*gi+1]   = w_even_swap[gi] ? r_slot[2*gi]   : r_slot[2*gi+1];
    end
    for (gi = 0; gi < HALF - 1; gi++) begin : g_odd
      assign w_odd_swap[gi]       = r_slot[2*gi+1] > r_slot[2*gi+2];
      assign w_odd_res[2*gi+1]    = w_odd_swap[gi] ? r_slot[2*gi+2] : r_slot[2*gi+1];
      assign w_odd_res[2*gi+2]    = w_odd_swap[gi] ? r_slot[2*gi+1] : r_slot[2*gi+2];
    end
  endgenerate

  assign w_odd_res[0]         = r_slot[0];
  assign w_odd_res[RUN_LEN-1] = r_slot[RUN_LEN-1];
  assign w_pass_res           = r_step[0] ? w_odd_res : w_even_res;

  assign w_accept    = en_in && (r_state == LOAD) && bus.in_valid;
  assign w_load_end  = w_accept && ((r_cnt == SW'(RUN_LEN - 1)) || bus.in_last);
  assign w_drain_end = (r_step == SW'(HALF - 1));

`ifdef RUN_SORT_EARLY_EXIT_EN
  logic r_clean_prev;
  logic w_pass_clean;

  assign w_pass_clean = r_step[0] ? ~|w_odd_swap : ~|w_even_swap;
  // An even and an odd pass both without swaps means the run is already ordered.
  assign w_sort_end   = (r_step == SW'(RUN_LEN - 1)) ||
                        ((r_step != '0) && r_clean_prev && w_pass_clean);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clean_prev <= 1'b0;
    end else if (en_in) begin
      r_clean_prev <= (r_state == SORT) ? w_pass_clean : 1'b0;
    end
  end
`else
  assign w_sort_end = (r_step == SW'(RUN_LEN - 1));
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (en_in) begin
      case (r_state)
        IDLE:    w_next = LOAD;
        LOAD:    if (w_load_end) w_next = SORT;
        SORT:    if (w_sort_end) w_next = DRAIN;
        DRAIN:   if (w_drain_end) w_next = r_last_seen ? DONE : LOAD;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_slot      <= '1;
      r_cnt       <= '0;
      r_step      <= '0;
      r_len       <= '0;
      r_addr      <= '0;
      r_run_base  <= '0;
      r_even      <= '0;
      r_odd       <= '0;
      r_wen       <= 1'b0;
      r_done      <= 1'b0;
      r_last_seen <= 1'b0;
    end else if (en_in) begin
      case (r_state)
        IDLE: begin
          r_slot      <= '1;
          r_cnt       <= '0;
          r_step      <= '0;
          r_len       <= '0;
          r_addr      <= '0;
          r_run_base  <= '0;
          r_wen       <= 1'b0;
          r_done      <= 1'b0;
          r_last_seen <= 1'b0;
        end
        LOAD: begin
          r_wen  <= 1'b0;
          r_step <= '0;
          if (w_accept) begin
            r_slot[r_cnt] <= bus.in_data;
            r_cnt         <= r_cnt + SW'(1);
            r_len         <= r_len + 32'd1;
            if (bus.in_last) r_last_seen <= 1'b1;
          end
        end
        SORT: begin
          r_slot <= w_pass_res;
          r_step <= w_sort_end ? '0 : r_step + SW'(1);
        end
        DRAIN: begin
          r_wen  <= 1'b1;
          r_even <= r_slot[{r_step, 1'b0}];
          r_odd  <= r_slot[{r_step, 1'b1}];
          r_addr <= r_run_base + AW'({r_step, 1'b0});
          // Sentinel refill lets a short final run drain its padding as all-ones.
          if (w_drain_end) begin
            r_step     <= '0;
            r_cnt      <= '0;
            r_slot     <= '1;
            r_run_base <= r_run_base + AW'(RUN_LEN);
          end else begin
            r_step <= r_step + SW'(1);
          end
        end
        DONE: begin
          r_wen  <= 1'b0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready       = en_in && (r_state == LOAD);
  assign bus.write_en_out   = r_wen && en_in;
  assign bus.phase_done_out = r_done && en_in;
  assign bus.even_data_out  = r_even;
  assign bus.odd_data_out   = r_odd;
  assign bus.write_addr_out = r_addr;
  assign bus.stream_len_out = r_len;
endmodule
